// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core arbiter slice.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int AES_BLK_W    = 128;
    localparam int AES_CORE_LAT = 22;

    // Index width for a port count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo N_REQ.
module aes_rr_pick
    import aes_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W:0] cand_s;
    logic           hit_s;

    // Walk the ports from rr_ptr upward; the first hit wins and later hits are masked.
    always_comb begin
        grant     = {N_REQ{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        any       = 1'b0;
        cand_s    = {(IDX_W+1){1'b0}};
        hit_s     = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_s    = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            cand_s    = (cand_s >= (IDX_W+1)'(N_REQ)) ? (cand_s - (IDX_W+1)'(N_REQ)) : cand_s;
            hit_s     = !any && req[cand_s[IDX_W-1:0]];
            grant     = grant | (hit_s ? (ONE_HOT_LSB << cand_s[IDX_W-1:0]) : {N_REQ{1'b0}});
            grant_idx = hit_s ? cand_s[IDX_W-1:0] : grant_idx;
            any       = any | hit_s;
        end
    end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one AES-128 core between N_REQ requesters with round-robin grant.
// Optional watchdog abort of a stuck core is enabled by AES_ARB_TIMEOUT_EN.
module aes_arbiter
    import aes_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*AES_BLK_W-1:0] req_key,
    input  logic [N_REQ*AES_BLK_W-1:0] req_di,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [AES_BLK_W-1:0]       rsp_data,
    output logic                       rsp_err,
    output logic                       core_rst,
    output logic                       core_start,
    output logic [AES_BLK_W-1:0]       core_key,
    output logic [AES_BLK_W-1:0]       core_di,
    input  logic [AES_BLK_W-1:0]       core_do,
    input  logic                       core_done
);

    localparam int               IDX_W       = idx_width(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_param_check
        $error("aes_arbiter: N_REQ must be 2..8 and TIMEOUT 2..65536");
    end

    arb_state_t           state_r;
    logic [IDX_W-1:0]     grant_idx_r;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     next_ptr_s;
    logic [N_REQ-1:0]     rsp_valid_r;
    logic [AES_BLK_W-1:0] rsp_data_r;
    logic                 core_start_r;
    logic [AES_BLK_W-1:0] core_key_r;
    logic [AES_BLK_W-1:0] core_di_r;
    logic [N_REQ-1:0]     pick_grant_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_any_s;

`ifdef AES_ARB_TIMEOUT_EN
    logic [15:0]          wd_cnt_r;
    logic                 rsp_err_r;
    logic                 core_rst_pulse_r;
`endif

    aes_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (pick_grant_s),
        .grant_idx (pick_idx_s),
        .any       (pick_any_s)
    );

    // Accept is offered only while idle, and only to the picked port.
    always_comb begin
        if (state_r == IDLE) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Pointer moves just past the port that was last served.
    always_comb begin
        if (grant_idx_r == IDX_W'(N_REQ - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_r + IDX_W'(1);
        end
    end

    // Job sequencer: accept, issue start, wait for the core, hold the response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            grant_idx_r  <= {IDX_W{1'b0}};
            rr_ptr_r     <= {IDX_W{1'b0}};
            rsp_valid_r  <= {N_REQ{1'b0}};
            rsp_data_r   <= {AES_BLK_W{1'b0}};
            core_start_r <= 1'b0;
            core_key_r   <= {AES_BLK_W{1'b0}};
            core_di_r    <= {AES_BLK_W{1'b0}};
`ifdef AES_ARB_TIMEOUT_EN
            wd_cnt_r         <= 16'd0;
            rsp_err_r        <= 1'b0;
            core_rst_pulse_r <= 1'b0;
`endif
        end else begin
`ifdef AES_ARB_TIMEOUT_EN
            core_rst_pulse_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        core_key_r   <= req_key[pick_idx_s*AES_BLK_W +: AES_BLK_W];
                        core_di_r    <= req_di[pick_idx_s*AES_BLK_W +: AES_BLK_W];
                        grant_idx_r  <= pick_idx_s;
                        core_start_r <= 1'b1;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start_r <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
                    wd_cnt_r     <= 16'd0;
`endif
                    state_r      <= BUSY;
                end
                BUSY: begin
                    if (core_done) begin
                        rsp_data_r  <= core_do;
`ifdef AES_ARB_TIMEOUT_EN
                        rsp_err_r   <= 1'b0;
`endif
                        rsp_valid_r <= ONE_HOT_LSB << grant_idx_r;
                        state_r     <= RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    // A core that never finishes is reset and the job answered with an error.
                    else if (wd_cnt_r == 16'(TIMEOUT - 1)) begin
                        rsp_data_r       <= {AES_BLK_W{1'b0}};
                        rsp_err_r        <= 1'b1;
                        core_rst_pulse_r <= 1'b1;
                        rsp_valid_r      <= ONE_HOT_LSB << grant_idx_r;
                        state_r          <= RESP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[grant_idx_r]) begin
                        rsp_valid_r <= {N_REQ{1'b0}};
                        rr_ptr_r    <= next_ptr_s;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    core_start_r <= 1'b0;
                    rsp_valid_r  <= {N_REQ{1'b0}};
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign core_start = core_start_r;
    assign core_key   = core_key_r;
    assign core_di    = core_di_r;

`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err  = rsp_err_r;
    assign core_rst = RST | core_rst_pulse_r;
`else
    assign rsp_err  = 1'b0;
    assign core_rst = RST;
`endif

endmodule

// File: tb/tb_aes_arbiter.sv
// Self-checking bench for aes_arbiter with a behavioural stand-in for the AES core.
module tb_aes_arbiter;
    import aes_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 64;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*128-1:0] req_key;
    logic [N*128-1:0] req_di;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [127:0]   rsp_data;
    logic           rsp_err;
    logic           core_rst;
    logic           core_start;
    logic [127:0]   core_key;
    logic [127:0]   core_di;
    logic [127:0]   core_do;
    logic           core_done;

    logic [127:0]   key_a [N];
    logic [127:0]   pt_a  [N];

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_ptr = 0;
    int rst_pulses = 0;

    // Core stand-in state.
    logic         cm_busy = 1'b0;
    int           cm_cnt = 0;
    logic [127:0] cm_res = 128'h0;
    logic         cm_done = 1'b0;
    logic         stray_done = 1'b0;
    logic         withhold = 1'b0;

    always #5 CLK = ~CLK;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_key[i*128 +: 128] = key_a[i];
        assign req_di[i*128 +: 128]  = pt_a[i];
    end

    aes_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_di(req_di),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_rst(core_rst), .core_start(core_start),
        .core_key(core_key), .core_di(core_di),
        .core_do(core_do), .core_done(core_done)
    );

    // Stand-in cipher: the real FIPS-197 answer for the known vector, a cheap mix otherwise.
    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5_5a5a_c3c3_3c3c_0f0f_f0f0_9696_6969;
    endfunction

    // Round-robin rule: first requesting port at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    assign core_do   = cm_res;
    assign core_done = cm_done | stray_done;

    // Core model: done is sampled by the arbiter AES_CORE_LAT cycles after start is sampled.
    always @(posedge CLK) begin
        cm_done <= 1'b0;
        if (core_rst) begin
            cm_busy <= 1'b0;
            cm_cnt  <= 0;
        end else if (core_start) begin
            cm_busy <= 1'b1;
            cm_cnt  <= 1;
            cm_res  <= fake_aes(core_key, core_di);
        end else if (cm_busy) begin
            cm_cnt <= cm_cnt + 1;
            if (cm_cnt == AES_CORE_LAT - 1) begin
                cm_busy <= 1'b0;
                cm_done <= !withhold;
            end
        end
    end

    always @(negedge CLK) begin
        if (core_rst && !RST) rst_pulses <= rst_pulses + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One full job for port exp_g, starting at a negedge with the request already presented.
    task automatic serve_one(input int exp_g, input int bp, input int exp_lat,
                             input logic exp_err, output logic [127:0] got);
        logic [N-1:0] oh;
        logic [127:0] exp_d;
        int lat;
        oh    = 4'b0001 << exp_g;
        exp_d = exp_err ? 128'h0 : fake_aes(key_a[exp_g], pt_a[exp_g]);
        #1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready != 4'b0000) break;
            @(negedge CLK);
        end
        chk("req_ready", {124'h0, req_ready}, {124'h0, oh});
        @(negedge CLK);
        chk("core_start", {127'h0, core_start}, 128'h1);
        chk("core_key", core_key, key_a[exp_g]);
        chk("core_di", core_di, pt_a[exp_g]);
        req_valid[exp_g] = 1'b0;
        lat = 1;
        while (rsp_valid == 4'b0000 && lat < 400) begin
            @(negedge CLK);
            lat++;
        end
        chk("rsp_valid", {124'h0, rsp_valid}, {124'h0, oh});
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", {127'h0, rsp_err}, {127'h0, exp_err});
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 4'($urandom) & ~oh;
            @(negedge CLK);
            chk("bp_valid", {124'h0, rsp_valid}, {124'h0, oh});
            chk("bp_data", rsp_data, exp_d);
            chk("bp_req_ready", {124'h0, req_ready}, 128'h0);
            chk("bp_core_start", {127'h0, core_start}, 128'h0);
        end
        got = rsp_data;
        rsp_ready = oh | 4'($urandom);
        @(negedge CLK);
        rsp_ready = 4'b0000;
        chk("rsp_drop", {124'h0, rsp_valid}, 128'h0);
        mdl_ptr = (exp_g + 1) % N;
    endtask

    typedef struct {
        logic [N-1:0] add;
        int           exp_g;
        int           bp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        logic [127:0] got;
        int g;

        tbl[0] = '{4'b1111, 0, 0};
        tbl[1] = '{4'b0000, 1, 0};
        tbl[2] = '{4'b0000, 2, 0};
        tbl[3] = '{4'b0000, 3, 0};
        tbl[4] = '{4'b1010, 1, 0};
        tbl[5] = '{4'b0000, 3, 0};
        tbl[6] = '{4'b0110, 1, 10};
        tbl[7] = '{4'b0000, 2, 0};
        tbl[8] = '{4'b1001, 3, 0};
        tbl[9] = '{4'b0000, 0, 2};

        key_a[0] = FIPS_KEY;
        pt_a[0]  = FIPS_PT;
        for (int i = 1; i < N; i++) begin
            key_a[i] = {$urandom, $urandom, $urandom, $urandom};
            pt_a[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        RST = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;

        repeat (3) @(negedge CLK);
        chk("rst_req_ready", {124'h0, req_ready}, 128'h0);
        chk("rst_rsp_valid", {124'h0, rsp_valid}, 128'h0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_rsp_err", {127'h0, rsp_err}, 128'h0);
        chk("rst_core_start", {127'h0, core_start}, 128'h0);
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_core_di", core_di, 128'h0);
        chk("rst_core_rst", {127'h0, core_rst}, 128'h1);
        RST = 1'b0;
        @(negedge CLK);

        // Directed table: fairness, FIPS vector, backpressure, wrap.
        for (int i = 0; i < 10; i++) begin
            req_valid = req_valid | tbl[i].add;
            serve_one(tbl[i].exp_g, tbl[i].bp, 2 + AES_CORE_LAT, 1'b0, got);
            if (i == 0) chk("fips_ct", got, FIPS_CT);
        end

        // Random traffic against the round-robin model.
        for (int j = 0; j < 25; j++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_valid[p] && $urandom_range(0, 1) == 1) begin
                    key_a[p] = {$urandom, $urandom, $urandom, $urandom};
                    pt_a[p]  = {$urandom, $urandom, $urandom, $urandom};
                    req_valid[p] = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) req_valid[$urandom_range(0, N-1)] = 1'b0;
            if (req_valid == 4'b0000) req_valid[$urandom_range(0, N-1)] = 1'b1;
            g = model_pick(req_valid, mdl_ptr);
            serve_one(g, $urandom_range(0, 3), 2 + AES_CORE_LAT, 1'b0, got);
        end
        req_valid = 4'b0000;

        // Stray done while idle must not produce a response or move the pointer.
        @(negedge CLK);
        stray_done = 1'b1;
        @(negedge CLK);
        stray_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("stray_rsp_valid", {124'h0, rsp_valid}, 128'h0);
        end
        req_valid = 4'b1111;
        serve_one(mdl_ptr, 0, 2 + AES_CORE_LAT, 1'b0, got);
        req_valid = 4'b0000;

        // Reset in the middle of BUSY aborts the job.
        @(negedge CLK);
        req_valid = 4'b0100;
        #1;
        chk("mid_req_ready", {124'h0, req_ready}, 128'h4);
        @(negedge CLK);
        req_valid = 4'b0000;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_core_rst", {127'h0, core_rst}, 128'h1);
        chk("mid_rsp_valid", {124'h0, rsp_valid}, 128'h0);
        chk("mid_rsp_data", rsp_data, 128'h0);
        chk("mid_core_start", {127'h0, core_start}, 128'h0);
        chk("mid_core_key", core_key, 128'h0);
        chk("mid_core_di", core_di, 128'h0);
        chk("mid_req_ready0", {124'h0, req_ready}, 128'h0);
        RST = 1'b0;
        mdl_ptr = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            chk("post_rst_rsp_valid", {124'h0, rsp_valid}, 128'h0);
        end
        req_valid = 4'b1010;
        serve_one(1, 0, 2 + AES_CORE_LAT, 1'b0, got);
        req_valid = 4'b0000;
        @(negedge CLK);

        // Core that never signals done.
        withhold = 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
        begin
            int p0;
            p0 = rst_pulses;
            req_valid = 4'b0100;
            serve_one(2, 0, 2 + TMO, 1'b1, got);
            chk("core_rst_pulses", 128'(rst_pulses - p0), 128'h1);
        end
`else
        req_valid = 4'b0100;
        #1;
        chk("stuck_req_ready", {124'h0, req_ready}, 128'h4);
        @(negedge CLK);
        req_valid = 4'b1011;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            chk("stuck_rsp_valid", {124'h0, rsp_valid}, 128'h0);
            chk("stuck_req_ready0", {124'h0, req_ready}, 128'h0);
        end
        req_valid = 4'b0000;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mdl_ptr = 0;
`endif
        withhold = 1'b0;
        req_valid = 4'b0000;
        @(negedge CLK);
        req_valid = 4'b1000;
        serve_one(3, 0, 2 + AES_CORE_LAT, 1'b0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
